sc_core_oz_rf_dumper: RTL and testbench
=======================================

// Module: sc_core_oz_rf_dumper
// PURPOSE
//  Read-side companion of the sc_core_oz register file. On request, walks a range of
//  architectural registers through the RF read port and streams {index,data} beats
//  over a valid/ready interface (debug/trace/end-of-test dump). Watches the core
//  write port so every dumped value equals the register's post-edge value.
// PARAMETERS
//  XLEN     32  data width of a register / beat
//  SKIP_X0  1   1: x0 never emitted; 0: x0 emitted as constant 0
// PORTS
//  Clk          in   1     core clock, single domain
//  Rst          in   1     synchronous reset, active-low (asserted when 0)
//  DumpReq      in   1     start request, sampled in IDLE only
//  DumpFirst    in   5     first register index, captured with DumpReq
//  DumpLast     in   5     last register index (inclusive), captured with DumpReq
//  RfRdAddr     out  5     RF read address (combinational read, same-cycle data)
//  RfRdData     in   XLEN  RF read data for RfRdAddr
//  CtrlRegWrEn  in   1     core RF write enable (snoop)
//  RegDst       in   5     core RF write index (snoop)
//  RegWrData    in   XLEN  core RF write data (snoop)
//  DumpValid    out  1     beat valid
//  DumpReady    in   1     sink accepts beat
//  DumpAddr     out  5     register index of beat
//  DumpData     out  XLEN  register value of beat
//  DumpLastBeat out  1     DumpValid && beat index == captured Last
//  DumpBusy     out  1     FSM not in IDLE
//  DumpDone     out  1     1-cycle pulse, dump complete
//  DumpErr      out  1     1-cycle pulse, request rejected (First > Last)
// BEHAVIOUR
//  Reset (Rst==0 at edge): state IDLE; all outputs 0; Ptr/Last regs 0. Applies mid-dump:
//   pending beat dropped, DumpValid 0 next cycle, no Done/Err pulse.
//  States: IDLE -> READ -> SEND -> (READ | DONE) -> IDLE.
//  IDLE: DumpReq=1 & First>Last -> DumpErr=1 next cycle, stay IDLE.
//   Else Ptr<=First (Ptr<=1 if SKIP_X0 & First==0), Last<=DumpLast, go READ.
//   If SKIP_X0 & First==0 & Last==0 -> go DONE directly (no beats).
//  READ (1 cycle): RfRdAddr=Ptr. Capture DumpData<=RfRdData, DumpAddr<=Ptr,
//   DumpValid<=1, go SEND. Bypass: CtrlRegWrEn & RegDst==Ptr & Ptr!=0 ->
//   capture RegWrData. Ptr==0 -> capture 0 regardless of RfRdData.
//  SEND: DumpAddr/DumpData/DumpValid held stable while !DumpReady (no re-sample;
//   value is a snapshot taken in READ). Handshake = DumpValid & DumpReady:
//   Ptr==Last -> DumpValid<=0, go DONE; else Ptr<=Ptr+1, DumpValid<=0, go READ.
//  DONE (1 cycle): DumpDone=1, go IDLE. DumpBusy=1 in READ/SEND/DONE.
//  Throughput: 1 beat per 2 cycles at DumpReady=1; latency req->first valid 2 cycles.
//  DumpReq while busy: ignored, no error. Ptr is 5 bits; Last<=31 so no wrap occurs.
//  RfRdAddr=0 outside READ. DumpValid never asserted outside SEND.
// STRUCTURE
//  sc_core_oz_pkg: add t_dump_state enum {DUMP_IDLE,DUMP_READ,DUMP_SEND,DUMP_DONE}
//   and localparam RF_IDX_W=5. Single module; no sub-module. All flops via MAFIA
//   DFF macros with sync active-low reset.
// TESTING
//  1. x1=0x11,x2=0x22,x3=0x33; req 1..3, Ready=1 -> beats (1,0x11),(2,0x22),(3,0x33,Last);
//     Done pulse 1 cycle after 3rd handshake; Busy high 7 cycles.
//  2. req 1..3, Ready=0 for 5 cycles on beat 2 -> Valid stays 1, Addr=2/Data=0x22 stable;
//     no beat lost or duplicated.
//  3. core writes x2<=0xDEADBEEF in the READ cycle for x2 -> beat (2,0xDEADBEEF);
//     write to x2 during SEND does not alter held beat.
//  4. First=5, Last=3 -> DumpErr 1 cycle, Valid/Busy stay 0.
//  5. First=Last=0: SKIP_X0=1 -> Done, zero beats; SKIP_X0=0 -> one beat (0,0x0) even
//     with RfRdData=0xFFFFFFFF.
//  6. Rst=0 after beat 1 of 1..4 -> Valid/Busy 0 next cycle; new req 7..7 -> single beat
//     (7,x7) then Done.

Source files
------------

// File: rtl/sc_core_oz_pkg.sv
// Shared types for the sc_core_oz register-file dump logic.
package sc_core_oz_pkg;

  localparam int RF_IDX_W = 5;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_READ,
    DUMP_SEND,
    DUMP_DONE
  } t_dump_state;

endpackage

// File: rtl/sc_core_oz_rf_dumper.sv
// Walks a range of architectural registers through the RF read port and streams
// {index,data} beats over valid/ready, bypassing a same-cycle core write.
module sc_core_oz_rf_dumper
  import sc_core_oz_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKIP_X0 = 1'b1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                DumpReq,
  input  logic [RF_IDX_W-1:0] DumpFirst,
  input  logic [RF_IDX_W-1:0] DumpLast,
  output logic [RF_IDX_W-1:0] RfRdAddr,
  input  logic [XLEN-1:0]     RfRdData,
  input  logic                CtrlRegWrEn,
  input  logic [RF_IDX_W-1:0] RegDst,
  input  logic [XLEN-1:0]     RegWrData,
  output logic                DumpValid,
  input  logic                DumpReady,
  output logic [RF_IDX_W-1:0] DumpAddr,
  output logic [XLEN-1:0]     DumpData,
  output logic                DumpLastBeat,
  output logic                DumpBusy,
  output logic                DumpDone,
  output logic                DumpErr
);

  localparam logic [RF_IDX_W-1:0] IDX_ONE = RF_IDX_W'(1);

  t_dump_state         state_q, state_d;
  logic [RF_IDX_W-1:0] ptr_q, ptr_d;
  logic [RF_IDX_W-1:0] last_q, last_d;
  logic [RF_IDX_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= DUMP_IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    case (state_q)
      DUMP_IDLE: begin
        if (DumpReq) begin
          if (DumpFirst > DumpLast) begin
            err_d = 1'b1;
          end else begin
            last_d = DumpLast;
            if (SKIP_X0 && (DumpFirst == '0)) begin
              ptr_d   = IDX_ONE;
              // A range holding only x0 has nothing to emit.
              state_d = (DumpLast == '0) ? DUMP_DONE : DUMP_READ;
            end else begin
              ptr_d   = DumpFirst;
              state_d = DUMP_READ;
            end
          end
        end
      end
      DUMP_READ: begin
        addr_d  = ptr_q;
        valid_d = 1'b1;
        // The beat must reflect the register's value after this edge.
        if (ptr_q == '0)
          data_d = '0;
        else if (CtrlRegWrEn && (RegDst == ptr_q))
          data_d = RegWrData;
        else
          data_d = RfRdData;
        state_d = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (valid_q && DumpReady) begin
          valid_d = 1'b0;
          if (ptr_q == last_q) begin
            state_d = DUMP_DONE;
          end else begin
            ptr_d   = ptr_q + IDX_ONE;
            state_d = DUMP_READ;
          end
        end
      end
      DUMP_DONE: state_d = DUMP_IDLE;
      default:   state_d = DUMP_IDLE;
    endcase
  end

  always_comb begin
    RfRdAddr     = (state_q == DUMP_READ) ? ptr_q : '0;
    DumpBusy     = (state_q != DUMP_IDLE);
    DumpDone     = (state_q == DUMP_DONE);
    DumpErr      = err_q;
    DumpValid    = valid_q;
    DumpAddr     = addr_q;
    DumpData     = data_q;
    DumpLastBeat = valid_q && (addr_q == last_q);
  end

endmodule

// File: tb/tb_sc_core_oz_rf_dumper.sv
// Directed bench for sc_core_oz_rf_dumper: one SKIP_X0=1 instance, one SKIP_X0=0 instance.
module tb_sc_core_oz_rf_dumper;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        DumpReq = 1'b0, DumpReqB = 1'b0;
  logic [4:0]  DumpFirst = '0, DumpLast = '0;
  logic        DumpReady = 1'b1;
  logic        CtrlRegWrEn = 1'b0;
  logic [4:0]  RegDst = '0;
  logic [31:0] RegWrData = '0;

  logic [4:0]  rd_addr_a, rd_addr_b, addr_a, addr_b;
  logic [31:0] rd_data_a, rd_data_b, data_a, data_b;
  logic        valid_a, lastb_a, busy_a, done_a, err_a;
  logic        valid_b, lastb_b, busy_b, done_b, err_b;

  logic [31:0] rf [32];

  int n_cmp = 0, n_err = 0, cyc = 0;
  int nb, busy_cnt, done_cnt, err_cnt, done_cyc;
  int b_addr [16], b_data [16], b_last [16], b_cyc [16];
  int nbb, done_b_cnt, bb_addr, bb_data, bb_last;
  int stall_addr, stall_left, bad;
  logic [31:0] stall_data;
  bit byp, byp_done;

  always #5 Clk = ~Clk;

  assign rd_data_a = rf[rd_addr_a];
  assign rd_data_b = rf[rd_addr_b];

  sc_core_oz_rf_dumper #(.XLEN(32), .SKIP_X0(1'b1)) u_dut_a (
    .Clk(Clk), .Rst(Rst), .DumpReq(DumpReq), .DumpFirst(DumpFirst), .DumpLast(DumpLast),
    .RfRdAddr(rd_addr_a), .RfRdData(rd_data_a), .CtrlRegWrEn(CtrlRegWrEn), .RegDst(RegDst),
    .RegWrData(RegWrData), .DumpValid(valid_a), .DumpReady(DumpReady), .DumpAddr(addr_a),
    .DumpData(data_a), .DumpLastBeat(lastb_a), .DumpBusy(busy_a), .DumpDone(done_a),
    .DumpErr(err_a)
  );

  sc_core_oz_rf_dumper #(.XLEN(32), .SKIP_X0(1'b0)) u_dut_b (
    .Clk(Clk), .Rst(Rst), .DumpReq(DumpReqB), .DumpFirst(DumpFirst), .DumpLast(DumpLast),
    .RfRdAddr(rd_addr_b), .RfRdData(rd_data_b), .CtrlRegWrEn(CtrlRegWrEn), .RegDst(RegDst),
    .RegWrData(RegWrData), .DumpValid(valid_b), .DumpReady(DumpReady), .DumpAddr(addr_b),
    .DumpData(data_b), .DumpLastBeat(lastb_b), .DumpBusy(busy_b), .DumpDone(done_b),
    .DumpErr(err_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic clear();
    nb = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0; done_cyc = -1;
    nbb = 0; done_b_cnt = 0; bb_addr = -1; bb_data = -1; bb_last = -1;
    stall_addr = -1; stall_left = 0; bad = 0; byp = 0; byp_done = 0;
  endtask

  // Samples outputs at negedge, then applies the RF model write just after the edge.
  task automatic step();
    @(negedge Clk);
    if (valid_a && DumpReady && nb < 16) begin
      b_addr[nb] = int'(addr_a); b_data[nb] = int'(data_a);
      b_last[nb] = int'(lastb_a); b_cyc[nb] = cyc; nb++;
    end
    if (busy_a) busy_cnt++;
    if (done_a) begin done_cnt++; done_cyc = cyc; end
    if (err_a) err_cnt++;
    if (valid_b && DumpReady) begin
      bb_addr = int'(addr_b); bb_data = int'(data_b); bb_last = int'(lastb_b); nbb++;
    end
    if (done_b) done_b_cnt++;
    @(posedge Clk); #1;
    cyc++;
    if (CtrlRegWrEn && RegDst != 5'd0) rf[RegDst] = RegWrData;
  endtask

  task automatic run(input int budget, input bit use_b);
    int n = 0;
    while (((use_b ? done_b_cnt : done_cnt) == 0) && n < budget) begin
      step(); n++;
      CtrlRegWrEn = 1'b0;
      if (byp && !byp_done && rd_addr_a == 5'd2) begin
        CtrlRegWrEn = 1'b1; RegDst = 5'd2; RegWrData = 32'hDEADBEEF; byp_done = 1;
      end
      if (valid_a && int'(addr_a) == stall_addr && stall_left > 0) begin
        DumpReady = 1'b0;
        if (data_a !== stall_data) bad++;
        if (byp && stall_left == 5) begin
          CtrlRegWrEn = 1'b1; RegDst = 5'd2; RegWrData = 32'h12345678;
        end
        stall_left--;
      end else begin
        DumpReady = 1'b1;
      end
    end
    CtrlRegWrEn = 1'b0;
    DumpReady   = 1'b1;
    if ((use_b ? done_b_cnt : done_cnt) == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_beat(input int i, input int a, input int d, input int l);
    chk($sformatf("beat%0d_addr", i), 64'(b_addr[i]), 64'(a));
    chk($sformatf("beat%0d_data", i), 64'(b_data[i]), 64'(d));
    chk($sformatf("beat%0d_last", i), 64'(b_last[i]), 64'(l));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[0] = 32'hFFFFFFFF;
    rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33; rf[4] = 32'h44; rf[7] = 32'h77;
    clear();

    step(); step();
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done_err", {done_a, err_a}, 0);
    chk("rst_rdaddr", rd_addr_a, 0);
    chk("rst_addr_data", {addr_a, data_a}, 0);
    Rst = 1'b1;
    step();

    // T1: plain dump of x1..x3
    clear();
    DumpFirst = 5'd1; DumpLast = 5'd3; DumpReq = 1'b1;
    step(); DumpReq = 1'b0;
    chk("t1_rdaddr_read", rd_addr_a, 1);
    run(40, 0);
    step(); step();
    chk("t1_nbeats", nb, 3);
    chk_beat(0, 1, 32'h11, 0);
    chk_beat(1, 2, 32'h22, 0);
    chk_beat(2, 3, 32'h33, 1);
    chk("t1_done_delay", done_cyc - b_cyc[2], 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_cycles", busy_cnt, 7);
    chk("t1_idle_after", busy_a, 0);

    // T2: backpressure on beat 2
    clear();
    stall_addr = 2; stall_left = 5; stall_data = 32'h22;
    DumpReq = 1'b1;
    step(); DumpReq = 1'b0;
    run(60, 0);
    chk("t2_stall_used", stall_left, 0);
    chk("t2_stall_stable", bad, 0);
    chk("t2_nbeats", nb, 3);
    chk_beat(1, 2, 32'h22, 0);
    chk_beat(2, 3, 32'h33, 1);

    // T3: core write bypass in READ, write during SEND ignored
    clear();
    byp = 1; stall_addr = 2; stall_left = 5; stall_data = 32'hDEADBEEF;
    DumpReq = 1'b1;
    step(); DumpReq = 1'b0;
    run(60, 0);
    chk("t3_bypass_done", byp_done, 1);
    chk("t3_stall_stable", bad, 0);
    chk("t3_nbeats", nb, 3);
    chk_beat(1, 2, 32'hDEADBEEF, 0);
    chk("t3_rf_x2", rf[2], 32'h12345678);

    // T4: First > Last rejected
    clear();
    DumpFirst = 5'd5; DumpLast = 5'd3; DumpReq = 1'b1;
    step(); DumpReq = 1'b0;
    chk("t4_err", err_a, 1);
    chk("t4_busy_valid", {busy_a, valid_a}, 0);
    step();
    chk("t4_err_pulse", err_a, 0);
    step(); step();
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_no_busy", busy_cnt, 0);

    // T5a: x0-only range with SKIP_X0=1
    clear();
    DumpFirst = 5'd0; DumpLast = 5'd0; DumpReq = 1'b1;
    step(); DumpReq = 1'b0;
    chk("t5a_done", done_a, 1);
    chk("t5a_valid", valid_a, 0);
    step(); step(); step();
    chk("t5a_nbeats", nb, 0);
    chk("t5a_done_cnt", done_cnt, 1);

    // T5b: x0 emitted as 0 with SKIP_X0=0 even though RF returns all-ones
    clear();
    DumpReqB = 1'b1;
    step(); DumpReqB = 1'b0;
    run(20, 1);
    chk("t5b_nbeats", nbb, 1);
    chk("t5b_beat", {32'(bb_addr), 32'(bb_data)}, 64'h0);
    chk("t5b_last", bb_last, 1);

    // T6: reset with a pending beat, then a single-register dump
    clear();
    DumpFirst = 5'd1; DumpLast = 5'd4; DumpReq = 1'b1;
    step(); DumpReq = 1'b0;
    step(); step(); step();
    chk("t6_beat2_pending", {valid_a, addr_a}, {1'b1, 5'd2});
    DumpReady = 1'b0; Rst = 1'b0;
    step();
    chk("t6_rst_valid_busy", {valid_a, busy_a}, 0);
    Rst = 1'b1; DumpReady = 1'b1;
    step(); step();
    chk("t6_nbeats_before", nb, 1);
    chk("t6_no_done", done_cnt, 0);
    clear();
    DumpFirst = 5'd7; DumpLast = 5'd7; DumpReq = 1'b1;
    step(); DumpReq = 1'b0;
    run(20, 0);
    chk("t6_nbeats", nb, 1);
    chk_beat(0, 7, 32'h77, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
